// File: rtl/spi_byte_queue.sv
// spi_byte_queue: byte-wide TX and RX FIFOs wrapped around a single-byte SPI
// engine handshake. The TX head is launched to the engine with start_o, the
// byte clocked back on the engine's completion level is stored in the RX FIFO.
// Received bytes that find the RX FIFO full are dropped and flagged sticky.
module spi_byte_queue #(
    parameter int Depth  = 8,
    parameter int LevelW = $clog2(Depth) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,

    // Producer side (TX FIFO write port)
    input  logic              tx_valid_i,
    input  logic [7:0]        tx_data_i,
    output logic              tx_ready_o,

    // Consumer side (RX FIFO read port)
    output logic              rx_valid_o,
    output logic [7:0]        rx_data_o,
    input  logic              rx_ready_i,

    // SPI engine side
    output logic              start_o,
    output logic [7:0]        byte_data_o,
    input  logic [7:0]        byte_data_i,
    input  logic              next_tx_byte_i,

    // Status
    output logic [LevelW-1:0] tx_level_o,
    output logic [LevelW-1:0] rx_level_o,
    output logic              busy_o,
    output logic              rx_overflow_o,
    input  logic              clear_i
);

    localparam int                PtrW      = $clog2(Depth);
    localparam logic [LevelW-1:0] LevelFull = LevelW'(Depth);
    localparam logic [LevelW-1:0] LevelOne  = LevelW'(1);
    localparam logic [PtrW-1:0]   PtrOne    = PtrW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;

    logic [7:0]        r_tx_mem [Depth];
    logic [PtrW-1:0]   r_tx_wr_ptr;
    logic [PtrW-1:0]   r_tx_rd_ptr;
    logic [LevelW-1:0] r_tx_level;

    logic [7:0]        r_rx_mem [Depth];
    logic [PtrW-1:0]   r_rx_wr_ptr;
    logic [PtrW-1:0]   r_rx_rd_ptr;
    logic [LevelW-1:0] r_rx_level;

    logic [7:0]        r_byte_data;
    logic              r_rx_overflow;

    logic              w_tx_ready;
    logic              w_tx_empty;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic [7:0]        w_tx_head;

    logic              w_rx_valid;
    logic              w_rx_full;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_rx_drop;

    logic              w_launch;
    logic              w_capture;

    // ------------------------------------------------------------------
    // Handshake decodes
    // ------------------------------------------------------------------
    // Ready/valid are derived from registered levels only, so no input can
    // combinationally reach tx_ready_o or rx_valid_o.
    assign w_tx_ready = (r_tx_level != LevelFull);
    assign w_tx_empty = (r_tx_level == '0);
    assign w_tx_push  = tx_valid_i && w_tx_ready;
    assign w_tx_head  = r_tx_mem[r_tx_rd_ptr];

    assign w_rx_valid = (r_rx_level != '0);
    assign w_rx_full  = (r_rx_level == LevelFull);
    assign w_rx_pop   = w_rx_valid && rx_ready_i;

    // Launch waits for the engine's completion level to be low so a long
    // completion pulse from the previous byte can never be mistaken for the
    // completion of the new one.
    assign w_launch   = (r_state == ST_IDLE) && !w_tx_empty && !next_tx_byte_i;
    assign w_tx_pop   = w_launch;

    // Capture happens only on the XFER->DRAIN edge, giving exactly one RX
    // push per byte however long next_tx_byte_i stays high.
    assign w_capture  = (r_state == ST_XFER) && next_tx_byte_i;

    // A pop in the capture cycle frees the slot the new byte needs.
    assign w_rx_push  = w_capture && (!w_rx_full || w_rx_pop);
    assign w_rx_drop  = w_capture && w_rx_full && !w_rx_pop;

    // ------------------------------------------------------------------
    // Engine sequencer FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state is assigned with <= so every flop samples
        // pre-edge values; = here would create order-dependent simulation.
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        // NOTE: the default assignment before the case keeps every path
        // covered, so no latch is inferred for w_state_next.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_launch)        w_state_next = ST_XFER;
            ST_XFER:  if (next_tx_byte_i)  w_state_next = ST_DRAIN;
            ST_DRAIN: if (!next_tx_byte_i) w_state_next = ST_IDLE;
            default:                       w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded engine outputs
    always_comb begin
        start_o = 1'b0;
        busy_o  = 1'b0;
        case (r_state)
            ST_XFER: begin
                start_o = 1'b1;
                busy_o  = 1'b1;
            end
            ST_DRAIN: begin
                busy_o  = 1'b1;
            end
            default: begin
                start_o = 1'b0;
                busy_o  = 1'b0;
            end
        endcase
    end

    // Byte presented to the engine, loaded on launch and held until the next one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_byte_data <= 8'h00;
        end else if (w_launch) begin
            r_byte_data <= w_tx_head;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------

    // TX storage write
    always_ff @(posedge clk_i) begin
        // NOTE: storage arrays carry no reset; emptiness is defined by the
        // pointers and level, so stale contents are never observed.
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= tx_data_i;
        end
    end

    // TX pointers and occupancy; push and pop together leave the level unchanged
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_level  <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + PtrOne;
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + PtrOne;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_level <= r_tx_level + LevelOne;
                2'b01:   r_tx_level <= r_tx_level - LevelOne;
                default: r_tx_level <= r_tx_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------

    // RX storage write of the captured engine byte
    always_ff @(posedge clk_i) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= byte_data_i;
        end
    end

    // RX pointers and occupancy; push and pop together leave the level unchanged
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_level  <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + PtrOne;
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + PtrOne;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_level <= r_rx_level + LevelOne;
                2'b01:   r_rx_level <= r_rx_level - LevelOne;
                default: r_rx_level <= r_rx_level;
            endcase
        end
    end

    // Sticky overflow flag; a new drop wins over a coincident clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_overflow <= 1'b0;
        end else if (w_rx_drop) begin
            r_rx_overflow <= 1'b1;
        end else if (clear_i) begin
            r_rx_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The RX head is masked while empty so the unreset storage never shows
    // through and the output reads 0x00 during and after reset.
    assign tx_ready_o    = w_tx_ready;
    assign tx_level_o    = r_tx_level;
    assign rx_valid_o    = w_rx_valid;
    assign rx_data_o     = w_rx_valid ? r_rx_mem[r_rx_rd_ptr] : 8'h00;
    assign rx_level_o    = r_rx_level;
    assign rx_overflow_o = r_rx_overflow;
    assign byte_data_o   = r_byte_data;

endmodule

// File: tb/tb_spi_byte_queue.sv
// tb_spi_byte_queue: scoreboard bench for spi_byte_queue. TX bytes are queued
// when pushed and compared when the engine is started; engine responses are
// queued when driven and compared when popped from the RX side.
module tb_spi_byte_queue;

    localparam int Depth  = 8;
    localparam int LevelW = $clog2(Depth) + 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              tx_valid_i = 1'b0;
    logic [7:0]        tx_data_i = 8'h00;
    logic              tx_ready_o;
    logic              rx_valid_o;
    logic [7:0]        rx_data_o;
    logic              rx_ready_i = 1'b0;
    logic              start_o;
    logic [7:0]        byte_data_o;
    logic [7:0]        byte_data_i = 8'h00;
    logic              next_tx_byte_i = 1'b0;
    logic [LevelW-1:0] tx_level_o;
    logic [LevelW-1:0] rx_level_o;
    logic              busy_o;
    logic              rx_overflow_o;
    logic              clear_i = 1'b0;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic       exp_ovf = 1'b0;

    spi_byte_queue #(.Depth(Depth), .LevelW(LevelW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .tx_valid_i     (tx_valid_i),
        .tx_data_i      (tx_data_i),
        .tx_ready_o     (tx_ready_o),
        .rx_valid_o     (rx_valid_o),
        .rx_data_o      (rx_data_o),
        .rx_ready_i     (rx_ready_i),
        .start_o        (start_o),
        .byte_data_o    (byte_data_o),
        .byte_data_i    (byte_data_i),
        .next_tx_byte_i (next_tx_byte_i),
        .tx_level_o     (tx_level_o),
        .rx_level_o     (rx_level_o),
        .busy_o         (busy_o),
        .rx_overflow_o  (rx_overflow_o),
        .clear_i        (clear_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        int guard;
        guard = 0;
        while (!tx_ready_o && guard < 100) begin
            tick();
            guard++;
        end
        check("tx_ready_wait", tx_ready_o, 1);
        tx_valid_i = 1'b1;
        tx_data_i  = b;
        tick();
        tx_valid_i = 1'b0;
        tx_exp.push_back(b);
    endtask

    task automatic wait_start(output bit ok);
        int guard;
        guard = 0;
        while (!start_o && guard < 100) begin
            tick();
            guard++;
        end
        ok = start_o;
        if (!ok) check("start_wait", start_o, 1);
    endtask

    // Play the engine for one byte: compare the launched byte, return rxb
    // with a completion level held for 'hold' cycles.
    task automatic respond(input logic [7:0] rxb, input int hold,
                           input bit pop_cap, input bit clr_cap);
        bit ok;
        logic [7:0] b;
        wait_start(ok);
        if (!ok) return;
        if (tx_exp.size() > 0) begin
            b = tx_exp.pop_front();
            check("byte_data", byte_data_o, b);
        end
        check("busy_xfer", busy_o, 1);
        byte_data_i    = rxb;
        next_tx_byte_i = 1'b1;
        if (pop_cap) begin
            check("rx_valid_cap", rx_valid_o, 1);
            if (rx_exp.size() > 0) check("rx_head_cap", rx_data_o, rx_exp[0]);
            rx_ready_i = 1'b1;
        end
        clear_i = clr_cap;
        tick();
        rx_ready_i = 1'b0;
        clear_i    = 1'b0;
        if (pop_cap && rx_exp.size() > 0) void'(rx_exp.pop_front());
        if (clr_cap) exp_ovf = 1'b0;
        if (rx_exp.size() < Depth) rx_exp.push_back(rxb);
        else exp_ovf = 1'b1;
        check("rx_level_cap", rx_level_o, rx_exp.size());
        check("ovf_cap", rx_overflow_o, exp_ovf);
        check("start_drain", start_o, 0);
        check("busy_drain", busy_o, 1);
        for (int i = 1; i < hold; i++) tick();
        next_tx_byte_i = 1'b0;
        tick();
        check("busy_idle", busy_o, 0);
        check("start_gap", start_o, 0);
    endtask

    task automatic pop_rx();
        check("rx_valid", rx_valid_o, 1);
        if (rx_exp.size() > 0) begin
            check("rx_data", rx_data_o, rx_exp[0]);
            void'(rx_exp.pop_front());
        end
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        check("rx_level_pop", rx_level_o, rx_exp.size());
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start"}, start_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_bdata"}, byte_data_o, 8'h00);
        check({tag, "_rxv"}, rx_valid_o, 0);
        check({tag, "_rxd"}, rx_data_o, 8'h00);
        check({tag, "_ovf"}, rx_overflow_o, 0);
        check({tag, "_txrdy"}, tx_ready_o, 1);
        check({tag, "_txlvl"}, tx_level_o, 0);
        check({tag, "_rxlvl"}, rx_level_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check_reset_values("rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Single byte: push 0xA5, engine returns 0x3C over a 4-cycle level
        push_tx(8'hA5);
        check("a5_txlvl", tx_level_o, 1);
        check("a5_idle", start_o, 0);
        tick();
        check("a5_start", start_o, 1);
        check("a5_bdata", byte_data_o, 8'hA5);
        check("a5_txlvl0", tx_level_o, 0);
        respond(8'h3C, 4, 1'b0, 1'b0);
        check("a5_rxlvl", rx_level_o, 1);
        pop_rx();

        // TX fill with the engine stalled; launch coincides with second push
        push_tx(8'h40);
        push_tx(8'h41);
        check("launch_push_lvl", tx_level_o, 1);
        for (int i = 2; i < Depth; i++) push_tx(8'h40 + 8'(i));
        check("txfill_lvl", tx_level_o, Depth - 1);
        check("txfill_rdy", tx_ready_o, 1);
        push_tx(8'h40 + 8'(Depth));
        check("txfull_lvl", tx_level_o, Depth);
        check("txfull_rdy", tx_ready_o, 0);
        tx_valid_i = 1'b1;
        tx_data_i  = 8'hEE;
        tick();
        tx_valid_i = 1'b0;
        check("txfull_ignored", tx_level_o, Depth);

        // Drain Depth+1 bytes into an unread RX FIFO: last one overflows
        for (int i = 0; i <= Depth; i++) respond(8'hC0 + 8'(i), 1 + (i % 3), 1'b0, 1'b0);
        check("ovf_lvl", rx_level_o, Depth);
        check("ovf_flag", rx_overflow_o, 1);
        check("ovf_tx_empty", tx_level_o, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_cleared", rx_overflow_o, 0);
        for (int i = 0; i < Depth; i++) pop_rx();
        check("ovf_rx_empty", rx_valid_o, 0);

        // RX push and pop at full, then overflow coinciding with clear
        for (int i = 0; i < Depth; i++) begin
            push_tx(8'h80 + 8'(i));
            respond(8'h20 + 8'(i), 2, 1'b0, 1'b0);
        end
        push_tx(8'h90);
        respond(8'h5A, 2, 1'b1, 1'b0);
        check("full_pp_lvl", rx_level_o, Depth);
        check("full_pp_ovf", rx_overflow_o, 0);
        push_tx(8'h91);
        respond(8'h6B, 2, 1'b0, 1'b1);
        check("ovf_clr_coincide", rx_overflow_o, 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clr2", rx_overflow_o, 0);
        for (int i = 0; i < Depth; i++) pop_rx();

        // Back-to-back bytes keep order and a low gap on start_o
        for (int i = 1; i <= 4; i++) push_tx(8'(i));
        for (int i = 1; i <= 4; i++) respond(8'hB0 + 8'(i), i, 1'b0, 1'b0);
        check("b2b_rxlvl", rx_level_o, 4);
        for (int i = 0; i < 4; i++) pop_rx();

        // Asynchronous reset while a byte is in flight
        push_tx(8'h55);
        push_tx(8'h66);
        begin
            bit ok;
            wait_start(ok);
        end
        check("pre_rst_start", start_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_values("arst");
        tx_exp.delete();
        rx_exp.delete();
        exp_ovf = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        tick();
        check("post_rst_rxlvl", rx_level_o, 0);
        check("post_rst_txlvl", tx_level_o, 0);
        check("post_rst_start", start_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
